// File: rtl/anyedge_flag_tx_if.sv
// Start/done handshake and flag wires between the sequencer and the any-edge flag transmitter.
interface anyedge_flag_tx_if #(
    parameter int unsigned CNT_W = 8
);
    logic             start;
    logic             flag_a;
    logic             flag_b;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] seq_count;

    modport master (
        output start,
        input  flag_a, flag_b, busy, done, seq_count
    );

    modport slave (
        input  start,
        output flag_a, flag_b, busy, done, seq_count
    );
endinterface

// File: rtl/anyedge_flag_tx.sv
// Delayed any-edge flag transmitter: drop flag_b, toggle flag_a after DLY_A, raise flag_b after DLY_B.
// Define ANYEDGE_TX_RETRIG_EN to let start while busy restart the sequence.
module anyedge_flag_tx #(
    parameter int unsigned DLY_A = 5,
    parameter int unsigned DLY_B = 10,
    parameter int unsigned CNT_W = 8
) (
    input  logic               i_clk,
    input  logic               i_rst,
    anyedge_flag_tx_if.slave   bus
);
    typedef enum logic [1:0] {StIdle, StWaitA, StWaitB} state_e;

    localparam logic [CNT_W-1:0] LP_DLY_A = CNT_W'(DLY_A);
    localparam logic [CNT_W-1:0] LP_DLY_B = CNT_W'(DLY_B);
    localparam logic [CNT_W-1:0] LP_ONE   = CNT_W'(1);

    state_e           r_state, w_state;
    logic [CNT_W-1:0] r_cnt, w_cnt;
    logic [CNT_W-1:0] r_seq_count, w_seq_count;
    logic             r_flag_a, w_flag_a;
    logic             r_flag_b, w_flag_b;
    logic             r_busy, w_busy;
    logic             r_done, w_done;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= StIdle;
            r_cnt       <= '0;
            r_seq_count <= '0;
            r_flag_a    <= 1'b0;
            r_flag_b    <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_cnt       <= w_cnt;
            r_seq_count <= w_seq_count;
            r_flag_a    <= w_flag_a;
            r_flag_b    <= w_flag_b;
            r_busy      <= w_busy;
            r_done      <= w_done;
        end
    end

    always_comb begin
        w_state     = r_state;
        w_cnt       = r_cnt;
        w_seq_count = r_seq_count;
        w_flag_a    = r_flag_a;
        w_flag_b    = r_flag_b;
        w_busy      = r_busy;
        w_done      = 1'b0;
`ifdef ANYEDGE_TX_RETRIG_EN
        // Restart keeps flag_b low and leaves flag_a alone; the new run toggles it again.
        if (bus.start && (r_state != StIdle)) begin
            w_state = StWaitA;
            w_cnt   = LP_ONE;
        end else
`endif
        begin
            unique case (r_state)
                StIdle: begin
                    if (bus.start) begin
                        w_state  = StWaitA;
                        w_cnt    = LP_ONE;
                        w_flag_b = 1'b0;
                        w_busy   = 1'b1;
                    end
                end
                StWaitA: begin
                    if (r_cnt == LP_DLY_A) begin
                        w_state  = StWaitB;
                        w_cnt    = LP_ONE;
                        w_flag_a = ~r_flag_a;
                    end else begin
                        w_cnt = r_cnt + LP_ONE;
                    end
                end
                StWaitB: begin
                    if (r_cnt == LP_DLY_B) begin
                        w_state     = StIdle;
                        w_cnt       = '0;
                        w_flag_b    = 1'b1;
                        w_busy      = 1'b0;
                        w_done      = 1'b1;
                        w_seq_count = r_seq_count + LP_ONE;
                    end else begin
                        w_cnt = r_cnt + LP_ONE;
                    end
                end
                default: begin
                    w_state = StIdle;
                end
            endcase
        end
    end

    assign bus.flag_a    = r_flag_a;
    assign bus.flag_b    = r_flag_b;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.seq_count = r_seq_count;
endmodule
